// File: rtl/fft_bf_pkg.sv
// Shared types and constants for the streaming radix-2 butterfly.
// Holds the FSM state enum, operand/result word indices and the
// internal sum-width helper used by the top and the reduction stage.
package fft_bf_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      MUL  = 2'd1,
      SUM  = 2'd2,
      OUT  = 2'd3
   } bfState_e;

   // Operand word order on the input bus
   localparam logic [2:0] OP_REW = 3'd0;
   localparam logic [2:0] OP_IMW = 3'd1;
   localparam logic [2:0] OP_REB = 3'd2;
   localparam logic [2:0] OP_IMB = 3'd3;
   localparam logic [2:0] OP_REA = 3'd4;
   localparam logic [2:0] OP_IMA = 3'd5;

   // Result word order on the output bus
   localparam logic [1:0] RES_REY = 2'd0;
   localparam logic [1:0] RES_IMY = 2'd1;
   localparam logic [1:0] RES_REZ = 2'd2;
   localparam logic [1:0] RES_IMZ = 2'd3;

   // Headroom for A +/- T before reduction back to the word width
   function automatic int unsigned sumWidth(input int unsigned width);
      return width + 32'd3;
   endfunction

endpackage

// File: rtl/fft_bf_sat.sv
// Reduces a WIDTH+3 bit signed sum to WIDTH bits and flags out-of-range.
// Build option: FFT_BF_SATURATE_EN defined clamps to the signed range,
// otherwise the low WIDTH bits are kept (wrap). The flag is the same either way.
// Ports:
//   sumIn    - signed sum, sumWidth(WIDTH) bits
//   resOut_c - reduced result, WIDTH bits (combinational)
//   ovf_c    - high when sumIn does not fit in WIDTH bits (combinational)
module fft_bf_sat
   import fft_bf_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic signed [sumWidth(WIDTH)-1:0] sumIn,
   output logic        [WIDTH-1:0]           resOut_c,
   output logic                              ovf_c
);

   localparam int unsigned SW = sumWidth(WIDTH);

   logic [SW-WIDTH:0] upperBits;

   // Value fits when everything from the target sign bit upward is a sign copy
   always_comb begin
      upperBits = sumIn[SW-1:WIDTH-1];
      ovf_c     = !((&upperBits) || !(|upperBits));
`ifdef FFT_BF_SATURATE_EN
      if (ovf_c) begin
         resOut_c = sumIn[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         resOut_c = sumIn[WIDTH-1:0];
      end
`else
      resOut_c = sumIn[WIDTH-1:0];
`endif
   end

endmodule

// File: rtl/fft_butterfly_stream.sv
// Streaming radix-2 DIT butterfly: Y = A + W*B, Z = A - W*B.
// Six operand words in (ReW, ImW, ReB, ImB, ReA, ImA), four results out
// (ReY, ImY, ReZ, ImZ), one shared signed multiplier used over four cycles.
// Build option: FFT_BF_SATURATE_EN selects clamping instead of wrapping.
// Ports:
//   Clock, nReset       - clock, asynchronous active-low reset
//   clear               - synchronous abort, also clears ovf
//   scale               - halve results, sampled with the first operand word
//   in_data/valid/ready - operand stream
//   out_data/valid/ready- result stream, out_data registered
//   busy                - butterfly in progress
//   ovf                 - sticky result-out-of-range flag
module fft_butterfly_stream
   import fft_bf_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned FRAC  = WIDTH - 1
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             clear,
   input  logic             scale,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             ovf
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned TW = PW + 1;
   localparam int unsigned SW = sumWidth(WIDTH);
   localparam logic signed [TW-1:0] RND = TW'(1) << (FRAC - 1);

   bfState_e                state, stateNext;
   logic [2:0]              cnt, cntNext;
   logic                    inXfer, outXfer;
   logic                    scaleReg;
   logic signed [WIDTH-1:0] opReg [6];
   logic signed [PW-1:0]    accReg;
   logic signed [SW-1:0]    tRe, tIm;
   logic [WIDTH-1:0]        resReg [4];
   logic signed [WIDTH-1:0] mulX, mulY;
   logic signed [PW-1:0]    prod;
   logic signed [TW-1:0]    tSum;
   logic signed [SW-1:0]    tRnd;
   logic signed [SW-1:0]    aRe, aIm;
   logic signed [SW-1:0]    sumRaw [4];
   logic signed [SW-1:0]    sumVal [4];
   logic [WIDTH-1:0]        satVal [4];
   logic [3:0]              satOvf;

   assign inXfer  = in_valid & in_ready;
   assign outXfer = out_valid & out_ready;

   // State register; cnt is the load word index, MUL step or result index
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state <= LOAD;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // Next-state logic; clear overrides any transfer in the same cycle
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      case (state)
         LOAD: begin
            if (inXfer) begin
               if (cnt == OP_IMA) begin
                  stateNext = MUL;
                  cntNext   = '0;
               end else begin
                  cntNext = cnt + 3'd1;
               end
            end
         end
         MUL: begin
            if (cnt == 3'd3) begin
               stateNext = SUM;
               cntNext   = '0;
            end else begin
               cntNext = cnt + 3'd1;
            end
         end
         SUM: stateNext = OUT;
         OUT: begin
            if (outXfer) begin
               if (cnt[1:0] == RES_IMZ) begin
                  stateNext = LOAD;
                  cntNext   = '0;
               end else begin
                  cntNext = cnt + 3'd1;
               end
            end
         end
         default: begin
            stateNext = LOAD;
            cntNext   = '0;
         end
      endcase
      if (clear) begin
         stateNext = LOAD;
         cntNext   = '0;
      end
   end

   // Multiplier operand select: ReW*ReB, ImW*ImB, ReW*ImB, ImW*ReB
   always_comb begin
      mulX = opReg[OP_REW];
      mulY = opReg[OP_REB];
      case (cnt[1:0])
         2'd1: begin mulX = opReg[OP_IMW]; mulY = opReg[OP_IMB]; end
         2'd2: begin mulX = opReg[OP_REW]; mulY = opReg[OP_IMB]; end
         2'd3: begin mulX = opReg[OP_IMW]; mulY = opReg[OP_REB]; end
         default: ;
      endcase
   end

   assign prod = PW'(mulX) * PW'(mulY);

   // Step 1 closes ReT as a difference, step 3 closes ImT as a sum; round half up
   assign tSum = cnt[1] ? (TW'(accReg) + TW'(prod)) : (TW'(accReg) - TW'(prod));
   assign tRnd = SW'((tSum + RND) >>> FRAC);

   assign aRe             = SW'(opReg[OP_REA]);
   assign aIm             = SW'(opReg[OP_IMA]);
   assign sumRaw[RES_REY] = aRe + tRe;
   assign sumRaw[RES_IMY] = aIm + tIm;
   assign sumRaw[RES_REZ] = aRe - tRe;
   assign sumRaw[RES_IMZ] = aIm - tIm;

   for (genvar i = 0; i < 4; i++) begin : gSat
      assign sumVal[i] = scaleReg ? (sumRaw[i] >>> 1) : sumRaw[i];
      fft_bf_sat #(.WIDTH(WIDTH)) uSat (
         .sumIn    (sumVal[i]),
         .resOut_c (satVal[i]),
         .ovf_c    (satOvf[i])
      );
   end

   // Datapath and registered outputs
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         ovf       <= 1'b0;
         scaleReg  <= 1'b0;
         accReg    <= '0;
         tRe       <= '0;
         tIm       <= '0;
         for (int i = 0; i < 6; i++) opReg[i] <= '0;
         for (int i = 0; i < 4; i++) resReg[i] <= '0;
      end else begin
         in_ready <= (stateNext == LOAD);
         busy     <= !((stateNext == LOAD) && (cntNext == 3'd0));
         if (clear) begin
            out_valid <= 1'b0;
            ovf       <= 1'b0;
         end else begin
            case (state)
               LOAD: begin
                  if (inXfer) begin
                     opReg[cnt] <= in_data;
                     if (cnt == OP_REW) scaleReg <= scale;
                  end
               end
               MUL: begin
                  case (cnt[1:0])
                     2'd1:    tRe    <= tRnd;
                     2'd3:    tIm    <= tRnd;
                     default: accReg <= prod;
                  endcase
               end
               SUM: begin
                  for (int i = 0; i < 4; i++) resReg[i] <= satVal[i];
                  if (|satOvf) ovf <= 1'b1;
               end
               OUT: begin
                  // First OUT cycle presents ReY; later words follow each accept
                  if (!out_valid) begin
                     out_data  <= resReg[RES_REY];
                     out_valid <= 1'b1;
                  end else if (outXfer) begin
                     if (cnt[1:0] == RES_IMZ) out_valid <= 1'b0;
                     else out_data <= resReg[2'(cnt + 3'd1)];
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fft_butterfly_stream.sv
// Self-checking bench for fft_butterfly_stream (WIDTH=8, FRAC=7).
// Follows FFT_BF_SATURATE_EN to pick clamped or wrapped expectations.
`timescale 1ns/1ps
module tb_fft_butterfly_stream;

   typedef logic [5:0][7:0] ops_t;
   typedef logic [3:0][7:0] res_t;
   typedef struct packed {
      ops_t op;
      logic sc;
      res_t exp;
      logic ovf;
   } vec_t;

   logic       Clock     = 1'b0;
   logic       nReset    = 1'b0;
   logic       clear     = 1'b0;
   logic       scale     = 1'b0;
   logic [7:0] in_data   = '0;
   logic       in_valid  = 1'b0;
   logic       out_ready = 1'b1;
   logic       in_ready, out_valid, busy, ovf;
   logic [7:0] out_data;

   int nVec      = 0;
   int nErr      = 0;
   int cyc       = 0;
   int acceptCyc = 0;
   int lastLat   = 0;

   vec_t       tbl [4];
   ops_t       o;
   res_t       r;
   bit         ov, sc, modelOvf, stable;
   logic [7:0] d, d0;
   int         c0;

   fft_butterfly_stream #(.WIDTH(8), .FRAC(7)) dut (
      .Clock     (Clock),
      .nReset    (nReset),
      .clear     (clear),
      .scale     (scale),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .ovf       (ovf)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1);
   end

   function automatic int s8(input logic [7:0] x);
      return int'(signed'(x));
   endfunction

   task automatic check(input string name, input int act, input int exp);
      nVec++;
      if (act != exp) begin
         nErr++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mkVec(input int rw, input int iw, input int rb, input int ib,
                                  input int ra, input int ia, input bit s,
                                  input int y0, input int y1, input int z0, input int z1,
                                  input bit v);
      vec_t t;
      t.op[0] = 8'(rw); t.op[1] = 8'(iw); t.op[2] = 8'(rb);
      t.op[3] = 8'(ib); t.op[4] = 8'(ra); t.op[5] = 8'(ia);
      t.sc = s;
      t.exp[0] = 8'(y0); t.exp[1] = 8'(y1); t.exp[2] = 8'(z0); t.exp[3] = 8'(z1);
      t.ovf = v;
      return t;
   endfunction

   // Reference: complex product rounded half up, then A +/- T, halve, reduce
   function automatic void bfModel(input ops_t op, input bit s, output res_t res, output bit v);
      int tr, ti;
      int y [4];
      tr = (s8(op[0]) * s8(op[2]) - s8(op[1]) * s8(op[3]) + 64) >>> 7;
      ti = (s8(op[0]) * s8(op[3]) + s8(op[1]) * s8(op[2]) + 64) >>> 7;
      y[0] = s8(op[4]) + tr;
      y[1] = s8(op[5]) + ti;
      y[2] = s8(op[4]) - tr;
      y[3] = s8(op[5]) - ti;
      v = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (s) y[i] = y[i] >>> 1;
         if (y[i] > 127 || y[i] < -128) begin
            v = 1'b1;
`ifdef FFT_BF_SATURATE_EN
            y[i] = (y[i] > 127) ? 127 : -128;
`else
            y[i] = ((y[i] + 128) & 255) - 128;
`endif
         end
         res[i] = 8'(y[i]);
      end
   endfunction

   task automatic pushWord(input logic [7:0] w, input bit s, input int gap, input bit first);
      int k = 0;
      in_valid = 1'b0;
      repeat (gap) @(negedge Clock);
      in_data  = w;
      scale    = s;
      in_valid = 1'b1;
      while (!in_ready && k < 64) begin
         @(negedge Clock);
         k++;
      end
      if (!in_ready) begin
         nVec++; nErr++;
         $display("FAIL in_ready timeout: got 0, want 1");
      end
      @(negedge Clock);
      if (first) acceptCyc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic pullWord(input int stall, output logic [7:0] w);
      int k = 0;
      out_ready = 1'b0;
      repeat (stall) @(negedge Clock);
      out_ready = 1'b1;
      while (!out_valid && k < 64) begin
         @(negedge Clock);
         k++;
      end
      if (!out_valid) begin
         nVec++; nErr++;
         $display("FAIL out_valid timeout: got 0, want 1");
      end
      w = out_data;
      @(negedge Clock);
   endtask

   task automatic runBf(input string tag, input ops_t op, input bit s, input int maxGap,
                        input int maxStall, input res_t e, input bit eOvf);
      logic [7:0] w;
      for (int i = 0; i < 6; i++)
         pushWord(op[i], s, (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0, i == 0);
      lastLat = 0;
      while (!out_valid && lastLat < 64) begin
         @(negedge Clock);
         lastLat++;
      end
      for (int i = 0; i < 4; i++) begin
         pullWord((maxStall > 0) ? int'($urandom_range(0, maxStall)) : 0, w);
         check($sformatf("%s res%0d", tag, i), s8(w), s8(e[i]));
      end
      check({tag, " ovf"}, int'(ovf), int'(eOvf));
   endtask

   initial begin
      tbl[0] = mkVec(0, -128, 30, 40, 10, 20, 1'b0, 50, -10, -30, 50, 1'b0);
      tbl[1] = mkVec(0, -128, 30, 40, 10, 20, 1'b1, 25, -5, -15, 25, 1'b0);
      tbl[2] = mkVec(127, 0, 10, -20, 5, 5, 1'b0, 15, -15, -5, 25, 1'b0);
`ifdef FFT_BF_SATURATE_EN
      tbl[3] = mkVec(-128, 0, 100, -100, 100, -100, 1'b0, 0, 0, 127, -128, 1'b1);
`else
      tbl[3] = mkVec(-128, 0, 100, -100, 100, -100, 1'b0, 0, 0, -56, 56, 1'b1);
`endif

      // Reset values
      repeat (3) @(negedge Clock);
      check("rst in_ready", int'(in_ready), 1);
      check("rst out_valid", int'(out_valid), 0);
      check("rst out_data", int'(out_data), 0);
      check("rst busy", int'(busy), 0);
      check("rst ovf", int'(ovf), 0);
      nReset = 1'b1;
      @(negedge Clock);

      // Directed vectors, each with latency from ImA accept to ReY valid
      for (int i = 0; i < 4; i++) begin
         runBf($sformatf("vec%0d", i), tbl[i].op, tbl[i].sc, 0, 0, tbl[i].exp, tbl[i].ovf);
         check($sformatf("vec%0d latency", i), lastLat, 6);
      end

      // clear with ReA on the bus: word dropped, ovf cleared, fresh load works
      o = tbl[0].op;
      for (int i = 0; i < 4; i++) pushWord(o[i], 1'b0, 0, i == 0);
      check("clr busy mid-load", int'(busy), 1);
      in_data  = o[4];
      in_valid = 1'b1;
      clear    = 1'b1;
      @(negedge Clock);
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clr ovf", int'(ovf), 0);
      check("clr busy", int'(busy), 0);
      check("clr in_ready", int'(in_ready), 1);
      runBf("after clear", tbl[0].op, 1'b0, 0, 0, tbl[0].exp, 1'b0);

      // Random operands with input gaps and output stalls
      modelOvf = 1'b0;
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 6; i++) o[i] = 8'($urandom);
         sc = 1'($urandom_range(0, 1));
         bfModel(o, sc, r, ov);
         modelOvf = modelOvf | ov;
         runBf($sformatf("rnd%0d", n), o, sc, 2, 2, r, modelOvf);
      end

      clear = 1'b1;
      @(negedge Clock);
      clear = 1'b0;
      check("idle clear ovf", int'(ovf), 0);

      // ImY held for 10 cycles with out_ready low
      o = tbl[0].op;
      for (int i = 0; i < 6; i++) pushWord(o[i], 1'b0, 0, i == 0);
      pullWord(0, d);
      check("stall ReY", s8(d), 50);
      out_ready = 1'b0;
      d0 = out_data;
      stable = 1'b1;
      repeat (10) begin
         @(negedge Clock);
         if (out_data !== d0 || out_valid !== 1'b1) stable = 1'b0;
      end
      check("stall hold", int'(stable), 1);
      pullWord(0, d);
      check("stall ImY", s8(d), -10);
      pullWord(0, d);
      check("stall ReZ", s8(d), -30);
      pullWord(0, d);
      check("stall ImZ", s8(d), 50);
      check("in_ready after ImZ", int'(in_ready), 1);
      check("busy after ImZ", int'(busy), 0);

      // Back-to-back butterflies: 16 cycles between first-word accepts
      runBf("b2b0", tbl[0].op, 1'b0, 0, 0, tbl[0].exp, 1'b0);
      c0 = acceptCyc;
      check("b2b in_ready", int'(in_ready), 1);
      runBf("b2b1", tbl[1].op, 1'b1, 0, 0, tbl[1].exp, 1'b0);
      check("b2b period", acceptCyc - c0, 16);

      // Asynchronous reset in the middle of OUT
      o = tbl[3].op;
      for (int i = 0; i < 6; i++) pushWord(o[i], 1'b0, 0, i == 0);
      pullWord(0, d);
      check("pre-reset ovf", int'(ovf), 1);
      check("pre-reset out_valid", int'(out_valid), 1);
      #2 nReset = 1'b0;
      #1;
      check("arst in_ready", int'(in_ready), 1);
      check("arst out_valid", int'(out_valid), 0);
      check("arst out_data", int'(out_data), 0);
      check("arst busy", int'(busy), 0);
      check("arst ovf", int'(ovf), 0);
      @(negedge Clock);
      nReset = 1'b1;
      @(negedge Clock);
      runBf("post-reset", tbl[0].op, 1'b0, 0, 0, tbl[0].exp, 1'b0);
      check("post-reset latency", lastLat, 6);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
